fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, drives the instruction-memory address, and loads the IF/ID pipeline register. Consumes the hazard detection unit's PCWrite/stallcontrol/flushcontrol outputs and the resolved branch/jump redirect. Feeds the decode stage, whose RS/RD fields go back to the hazard detection unit.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush or bubble

Ports:
- Clk  in  1  pipeline clock; all state updates on rising edge
- Rst  in  1  reset; one clock, synchronous, active-low (Rst=0 resets on the rising edge of Clk)
- PCWrite  in  1  1 = freeze PC this cycle (hazard unit encoding)
- stallcontrol  in  1  1 = hold IF/ID contents
- flushcontrol  in  1  1 = replace IF/ID with NOP_WORD
- RedirectValid  in  1  taken branch or jump resolved this cycle
- RedirectTarget  in  32  new PC when RedirectValid=1; bits [1:0] ignored and forced to 0
- ImemAddr  out  32  fetch address (= PC register, combinational from it)
- ImemRdata  in  32  instruction word, valid when ImemReady=1
- ImemReady  in  1  memory returns ImemRdata for ImemAddr this cycle
- FetchPC  out  32  current PC register
- IFID_Instr  out  32  registered instruction to decode
- IFID_PCPlus4  out  32  registered PC+4 of that instruction
- IFID_Valid  out  1  1 = IFID_Instr is a real instruction, 0 = bubble
- StallCount  out  32  stall-cycle counter (see Configuration)
- FlushCount  out  32  flush-cycle counter (see Configuration)

## Operation
- States: BOOT, FETCH, REDIR_PEND.
- Reset: PC=RESET_PC, IFID_Instr=NOP_WORD, IFID_PCPlus4=0, IFID_Valid=0, state=BOOT, counters=0.
- BOOT: one cycle; IF/ID stays bubble; PC unchanged; -> FETCH.
- FETCH, evaluated in priority order each cycle:
  1. RedirectValid=1 and ImemReady=1: PC<=RedirectTarget; IF/ID<=bubble (NOP_WORD, Valid=0). Stays in FETCH.
  2. RedirectValid=1 and ImemReady=0: latch target into internal register; IF/ID<=bubble; -> REDIR_PEND.
  3. flushcontrol=1: IF/ID<=bubble. PC advances to PC+4 only if PCWrite=0 and ImemReady=1.
  4. stallcontrol=1 or PCWrite=1: PC held. IF/ID held when stallcontrol=1; otherwise IF/ID<=bubble.
  5. ImemReady=1: IF/ID<={ImemRdata, PC+4, Valid=1}; PC<=PC+4.
  6. ImemReady=0: PC held; IF/ID<=bubble.
- REDIR_PEND: ImemAddr still shows the old PC. ImemRdata is discarded. IF/ID is held as bubble. When ImemReady=1, PC<=latched target and the state goes -> FETCH. A new RedirectValid in this state overwrites the latched target (last redirect wins).
- Redirect outranks stall, flush and PCWrite. This matches the hazard unit, where Branch/Jump have priority.
- PC+4 arithmetic is modulo 2^32: PC=32'hFFFF_FFFC wraps to 0.
- Rst=0 in any state, including REDIR_PEND, returns to the reset values on that edge. A pending redirect is dropped.

## Timing
- ImemAddr/FetchPC are valid throughout cycle N. The instruction is captured at the end of cycle N and appears on IFID_* in cycle N+1.
- Redirect at cycle N with ImemReady=1: ImemAddr=target in cycle N+1. The first valid target instruction is on IFID in N+2.
- Stall: IFID_* are bit-identical for every stalled cycle. Fetch resumes the cycle after stallcontrol/PCWrite drop.
- No combinational path from any input to an output, except ImemAddr, which depends only on the PC register.

## Configuration
- FETCH_PERF_CNT_EN defined:
  - StallCount increments in every FETCH cycle where rule 4 applies.
  - FlushCount increments in every cycle where IF/ID is loaded with a bubble because of rule 1, 2 or 3.
  - Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- Not defined: counter logic is absent and StallCount=FlushCount=0 constantly.

## Test plan
- Reset then free-run, ImemReady=1, memory word = address: after BOOT, IFID_Instr sequence is 0,4,8,... with IFID_PCPlus4 = 4,8,12, IFID_Valid=1.
- Stall 3 cycles with IFID holding 32'h8C22_0004: stallcontrol=PCWrite=1 -> IFID unchanged for 3 cycles, ImemAddr frozen; the next instruction follows one cycle after release.
- RedirectValid with target 32'h0000_0103 during a stall -> PC=32'h0000_0100 next cycle, one bubble, stall ignored.
- Redirect with ImemReady=0 for 2 cycles, second redirect to 32'h200 in REDIR_PEND -> PC loads 32'h200 when ImemReady rises, stale data discarded.
- PC=32'hFFFF_FFFC, ImemReady=1 -> next PC=0, IFID_PCPlus4=0. Rst=0 asserted in REDIR_PEND -> PC=RESET_PC, no redirect applied.
- With FETCH_PERF_CNT_EN: 5 stall cycles + 2 flushes -> StallCount=5, FlushCount=2. Without it, both read 0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction-memory and IF/ID bus bundle for fetch_stage
//
// Signals:
//   ImemAddr      fetch address driven by the fetch stage
//   ImemRdata     instruction word returned by memory
//   ImemReady     memory returns ImemRdata for ImemAddr this cycle
//   IFID_Instr    registered instruction to decode
//   IFID_PCPlus4  registered PC+4 of that instruction
//   IFID_Valid    1 = real instruction, 0 = bubble
// Modports:
//   master  fetch stage side
//   slave   memory / decode side
interface fetch_stage_if;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata;
  logic        ImemReady;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;

  modport master (
    output ImemAddr,
    input  ImemRdata,
    input  ImemReady,
    output IFID_Instr,
    output IFID_PCPlus4,
    output IFID_Valid
  );

  modport slave (
    input  ImemAddr,
    output ImemRdata,
    output ImemReady,
    input  IFID_Instr,
    input  IFID_PCPlus4,
    input  IFID_Valid
  );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC register, imem address, IF/ID register
//
// Parameters:
//   RESET_PC  PC value loaded on reset
//   NOP_WORD  instruction word placed in IF/ID for a bubble
// Optional feature macro:
//   FETCH_PERF_CNT_EN  enables saturating stall/flush cycle counters
// Ports:
//   Clk             pipeline clock, rising edge
//   Rst             synchronous active-low reset
//   PCWrite         1 = freeze PC this cycle
//   stallcontrol    1 = hold IF/ID contents
//   flushcontrol    1 = replace IF/ID with a bubble
//   RedirectValid   taken branch/jump resolved this cycle
//   RedirectTarget  redirect PC, bits [1:0] forced to 0
//   bus             imem request/response and IF/ID outputs (master modport)
//   FetchPC         current PC register
//   StallCount      stall-cycle counter (0 when counters disabled)
//   FlushCount      flush-cycle counter (0 when counters disabled)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               PCWrite,
  input  logic               stallcontrol,
  input  logic               flushcontrol,
  input  logic               RedirectValid,
  input  logic [31:0]        RedirectTarget,
  fetch_stage_if.master      bus,
  output logic [31:0]        FetchPC,
  output logic [31:0]        StallCount,
  output logic [31:0]        FlushCount
);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    FETCH      = 2'd1,
    REDIR_PEND = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] redir_aligned;

  // Wraps modulo 2^32 naturally.
  assign pc_plus4      = pc_q + 32'd4;
  assign redir_aligned = {RedirectTarget[31:2], 2'b00};

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
      instr_q <= NOP_WORD;
      pcp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      pcp4_q  <= pcp4_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;

    unique case (state_q)
      BOOT: begin
        instr_d = NOP_WORD;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
        state_d = FETCH;
      end

      FETCH: begin
        if (RedirectValid) begin
          // Redirect outranks flush, stall and PCWrite.
          instr_d = NOP_WORD;
          pcp4_d  = 32'd0;
          valid_d = 1'b0;
          if (bus.ImemReady) begin
            pc_d = redir_aligned;
          end else begin
            // The in-flight fetch of the old PC must complete first.
            tgt_d   = redir_aligned;
            state_d = REDIR_PEND;
          end
        end else if (flushcontrol) begin
          instr_d = NOP_WORD;
          pcp4_d  = 32'd0;
          valid_d = 1'b0;
          if (!PCWrite && bus.ImemReady) begin
            pc_d = pc_plus4;
          end
        end else if (stallcontrol || PCWrite) begin
          // PC frozen; IF/ID either held or bubbled.
          if (!stallcontrol) begin
            instr_d = NOP_WORD;
            pcp4_d  = 32'd0;
            valid_d = 1'b0;
          end
        end else if (bus.ImemReady) begin
          instr_d = bus.ImemRdata;
          pcp4_d  = pc_plus4;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
        end else begin
          instr_d = NOP_WORD;
          pcp4_d  = 32'd0;
          valid_d = 1'b0;
        end
      end

      REDIR_PEND: begin
        // Data returned here belongs to the abandoned path and is dropped.
        instr_d = NOP_WORD;
        pcp4_d  = 32'd0;
        valid_d = 1'b0;
        if (RedirectValid) begin
          tgt_d = redir_aligned;
        end
        if (bus.ImemReady) begin
          // A redirect arriving on the completion cycle is the newest one.
          pc_d    = RedirectValid ? redir_aligned : tgt_q;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign bus.ImemAddr     = pc_q;
  assign FetchPC          = pc_q;
  assign bus.IFID_Instr   = instr_q;
  assign bus.IFID_PCPlus4 = pcp4_q;
  assign bus.IFID_Valid   = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic        stall_evt;
  logic        flush_evt;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  // Mirrors the priority chain in FETCH: stall counts only when no
  // redirect or flush took precedence.
  assign stall_evt = (state_q == FETCH) && !RedirectValid && !flushcontrol &&
                     (stallcontrol || PCWrite);
  assign flush_evt = (state_q == FETCH) && (RedirectValid || flushcontrol);

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF)) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
`else
  assign StallCount = 32'd0;
  assign FlushCount = 32'd0;
`endif

endmodule
